addshift_multiplier: RTL
========================

# addshift_multiplier

Parametrised sequential add-shift multiplier: control FSM, iteration counter and the X/A/B datapath registers in one block. It computes a WIDTH×WIDTH product in signed (two's-complement, subtract on the final bit) or unsigned mode. The result sits in {A,B} with a sign/carry bit in X. It is the width-generic replacement for the fixed 8-bit multiplier control and sits between the switch/button inputs and the hex-display drivers.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32
- CNT_W, $clog2(WIDTH), iteration counter width (derived, not overridden)
- Clk  in  1  clock
- Reset  in  1  synchronous, active-high; clock Clk
- Run  in  1  start request, level-sensitive, debounced upstream
- ClearA_LoadB  in  1  in IDLE: clear A and X, load B from S
- Signed_Mode  in  1  1 = two's-complement, 0 = unsigned; sampled in START
- S  in  WIDTH  multiplicand source, and B load value
- Aval  out  WIDTH  A register (product upper half)
- Bval  out  WIDTH  B register (product lower half)
- Xval  out  1  X register (sign extension or carry)
- Busy  out  1  high in START, ADD and SHIFT
- Done  out  1  high in HOLD

## Operation
- Internal registers: A, B, M (multiplicand latch, WIDTH bits), X, mode, cnt (CNT_W bits).
- State machine: IDLE, START, ADD, SHIFT, HOLD.
  - IDLE:
    - Run=1 -> START.
    - Else, if ClearA_LoadB=1 then A<=0, X<=0, B<=S.
  - START: A<=0, X<=0, M<=S, mode<=Signed_Mode, cnt<=0 -> ADD. B is kept, so consecutive Runs multiply the previous low half by S.
  - ADD:
    - If B[0]=1, load {X,A} <= sum[WIDTH:0].
    - Else A and X hold.
    - Always -> SHIFT.
  - SHIFT: shift {X,A,B} right by 1.
    - If cnt==WIDTH-1 -> HOLD; else cnt<=cnt+1 -> ADD.
  - HOLD: registers hold. Run=0 -> IDLE; otherwise stay. One multiply per Run press.
- Arithmetic in ADD, computed at WIDTH+1 bits:
  - Signed: sum = {A[W-1],A} + {M[W-1],M}. On the last iteration (cnt==WIDTH-1) it is {A[W-1],A} − {M[W-1],M}, i.e. add of ~M plus 1.
  - Unsigned: sum = {1'b0,A} + {1'b0,M}. Never subtracts; X receives the carry-out.
- Shift in SHIFT:
  - Signed: X is kept, A <= {X,A[W-1:1]}, B <= {A[0],B[W-1:1]}.
  - Unsigned: same, then X <= 0.
- Result: the 2·WIDTH-bit product is {A,B}.
  - Signed: X equals A[W-1] when HOLD is reached.
  - Unsigned: X=0 in HOLD.
- ClearA_LoadB is ignored outside IDLE. S, Signed_Mode and ClearA_LoadB changes during Busy have no effect.
- Reset has priority over everything, including mid-operation: state=IDLE, A=0, B=0, X=0, M=0, cnt=0, mode=0.

## Timing
- Reset values: Aval=0, Bval=0, Xval=0, Busy=0, Done=0.
- All outputs are registered or decoded from the state register only; no combinational path from any input to any output.
- Run sampled high in IDLE at edge k:
  - State is START after edge k.
  - First ADD after edge k+1.
  - HOLD after edge k+1+2·WIDTH.
- Busy is high for exactly 1+2·WIDTH cycles; Done rises on the same edge that Busy falls.
- Leaving HOLD: Run=0 sampled at edge j -> IDLE after edge j. Run re-asserted at edge j+1 starts a new multiply.
- Run=1 held continuously yields exactly one multiply, then the block sits in HOLD.
- ClearA_LoadB in IDLE takes effect at the next edge. If Run and ClearA_LoadB are both 1 in IDLE, Run wins and no load occurs.

## Test plan
- Unsigned, WIDTH=8: ClearA_LoadB with S=0xFF, then Run with S=0xFF -> HOLD with A=0xFE, B=0x01, X=0; Done exactly 17 cycles after Run was sampled.
- Signed, WIDTH=8:
  - B=0xFF (−1), S=0x07 -> A=0xFF, B=0xF9, X=1 (−7).
  - B=0x80, S=0x80 -> A=0x40, B=0x00, X=0 (+16384).
- Consecutive runs, signed: B=0x02, S=0x03, Run -> A:B=0x0006. Release Run, press again with S=0x03 -> A:B=0x0012. Run held high for 40 cycles -> only one multiply, Done stays high.
- Reset mid-operation: assert Reset 5 cycles after Run -> next edge all outputs 0, state IDLE. A following Run with ClearA_LoadB-loaded operands computes correctly.
- WIDTH=4 instance:
  - Signed B=0x8, S=0x7 -> A=0xC, B=0x8 (−56), X=1; Busy 9 cycles.
  - ClearA_LoadB toggled while Busy -> B unchanged.

Source files
------------

// File: rtl/addshift_multiplier.sv
// Sequential add-shift multiplier: WIDTH x WIDTH product in {A,B}, sign/carry in X.
// Signed mode subtracts the multiplicand on the final bit (two's-complement MSB weight).
module addshift_multiplier #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic             ClearA_LoadB,
    input  logic             Signed_Mode,
    input  logic [WIDTH-1:0] S,
    output logic [WIDTH-1:0] Aval,
    output logic [WIDTH-1:0] Bval,
    output logic             Xval,
    output logic             Busy,
    output logic             Done
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_ADD,
        ST_SHIFT,
        ST_HOLD
    } state_t;

    state_t           state_q, state_next;
    logic [WIDTH-1:0] a_q, a_next;
    logic [WIDTH-1:0] b_q, b_next;
    logic [WIDTH-1:0] m_q, m_next;
    logic             x_q, x_next;
    logic             mode_q, mode_next;
    logic [CNT_W-1:0] cnt_q, cnt_next;
    logic             busy_q, busy_next;
    logic             done_q, done_next;

    logic             last_iter;
    logic             sub;
    logic [WIDTH:0]   a_ext;
    logic [WIDTH:0]   m_ext;
    logic [WIDTH:0]   m_op;
    logic [WIDTH:0]   sum;

    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

    // Partial-product adder at WIDTH+1 bits; the extra bit lands in X.
    always_comb begin
        sub   = mode_q & last_iter;
        a_ext = {mode_q & a_q[WIDTH-1], a_q};
        m_ext = {mode_q & m_q[WIDTH-1], m_q};
        m_op  = sub ? ~m_ext : m_ext;
        sum   = a_ext + m_op + {{WIDTH{1'b0}}, sub};
    end

    // Next-state and datapath update.
    always_comb begin
        state_next = state_q;
        a_next     = a_q;
        b_next     = b_q;
        m_next     = m_q;
        x_next     = x_q;
        mode_next  = mode_q;
        cnt_next   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (Run) begin
                    state_next = ST_START;
                end else if (ClearA_LoadB) begin
                    a_next = '0;
                    x_next = 1'b0;
                    b_next = S;
                end
            end
            ST_START: begin
                a_next     = '0;
                x_next     = 1'b0;
                m_next     = S;
                mode_next  = Signed_Mode;
                cnt_next   = '0;
                state_next = ST_ADD;
            end
            ST_ADD: begin
                if (b_q[0]) begin
                    x_next = sum[WIDTH];
                    a_next = sum[WIDTH-1:0];
                end
                state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                a_next = {x_q, a_q[WIDTH-1:1]};
                b_next = {a_q[0], b_q[WIDTH-1:1]};
                x_next = mode_q ? x_q : 1'b0;
                if (last_iter) begin
                    state_next = ST_HOLD;
                end else begin
                    cnt_next   = cnt_q + CNT_W'(1);
                    state_next = ST_ADD;
                end
            end
            ST_HOLD: begin
                if (!Run) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        busy_next = (state_next == ST_START) || (state_next == ST_ADD) ||
                    (state_next == ST_SHIFT);
        done_next = (state_next == ST_HOLD);
    end

    // State, datapath and status registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
            x_q     <= 1'b0;
            mode_q  <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_next;
            a_q     <= a_next;
            b_q     <= b_next;
            m_q     <= m_next;
            x_q     <= x_next;
            mode_q  <= mode_next;
            cnt_q   <= cnt_next;
            busy_q  <= busy_next;
            done_q  <= done_next;
        end
    end

    assign Aval = a_q;
    assign Bval = b_q;
    assign Xval = x_q;
    assign Busy = busy_q;
    assign Done = done_q;

endmodule
